// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and a constant log2 helper
// used to derive the byte-offset width of the register index.
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// AXI4-Lite bus bundle between interconnect (master) and register file (slave).
// Carries the five AXI-Lite channels: AW, W, B, AR, R.
interface axil_regfile_if
  import axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7
) ();

  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  axil_resp_t                        S_AXI_BRESP;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  axil_resp_t                        S_AXI_RRESP;

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_BREADY,
    input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_ARREADY,
    output S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP
  );

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_BREADY,
    output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_ARREADY,
    input  S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP
  );

endinterface

// File: rtl/axil_wr_hold.sv
// One-deep valid/payload hold for a write-side channel (AW or W).
// Ports: clk, rst (sync, active-high); load captures din and sets held;
// drain empties the hold (drain wins over load); held/dout expose contents.
module axil_wr_hold #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] din,
  output logic         held,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      held <= 1'b0;
      dout <= '0;
    end else if (drain) begin
      held <= 1'b0;
    end else if (load) begin
      held <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// Parametrised AXI4-Lite slave register file.
// Ports: S_AXI_ACLK / S_AXI_ARESET (sync, active-high) clock and reset;
// s_axi: AXI4-Lite slave channels; o_regs: flat register contents,
// register i at bits [i*DW +: DW]. Out-of-range accesses answer SLVERR.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7,
  parameter int unsigned NUM_REGS           = 32,
  parameter bit          OPT_LOWPOWER       = 1'b0
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  axil_regfile_if.slave                          s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] o_regs
);

  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW      = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned STRBW   = DW / 8;
  localparam int unsigned ADDRLSB = clog2(STRBW);
  localparam int unsigned IDXW    = AW - ADDRLSB;

  logic              aw_hs, w_hs, ar_hs, b_free, wfire;
  logic              aw_held, w_held;
  logic [IDXW-1:0]   aw_hold_idx, aw_live_idx, w_idx, ar_idx;
  logic [STRBW+DW-1:0] w_hold_pl, w_pl;
  logic [STRBW-1:0]  wstrb;
  logic [DW-1:0]     wdata, wmask;
  logic              w_in_range, ar_in_range;
  logic [DW-1:0]     rd_acc [NUM_REGS+1];
  logic              unused_ok;

  // Protection bits and byte offsets within a word carry no meaning here.
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[ADDRLSB-1:0],
                       s_axi.S_AXI_ARADDR[ADDRLSB-1:0]};

  // Ready signals; all held low while reset is asserted.
  assign s_axi.S_AXI_AWREADY = !S_AXI_ARESET && !aw_held;
  assign s_axi.S_AXI_WREADY  = !S_AXI_ARESET && !w_held;
  assign s_axi.S_AXI_ARREADY = !S_AXI_ARESET &&
                               (!s_axi.S_AXI_RVALID || s_axi.S_AXI_RREADY);

  assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs   = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
  assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign b_free = !s_axi.S_AXI_BVALID || s_axi.S_AXI_BREADY;

  // A write fires once address and data are both present (held or live)
  // and the B slot can take the response.
  assign wfire = !S_AXI_ARESET && b_free &&
                 (aw_held || s_axi.S_AXI_AWVALID) &&
                 (w_held  || s_axi.S_AXI_WVALID);

  assign aw_live_idx = s_axi.S_AXI_AWADDR[AW-1:ADDRLSB];
  assign ar_idx      = s_axi.S_AXI_ARADDR[AW-1:ADDRLSB];

  axil_wr_hold #(.W(IDXW)) u_aw_hold (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .load  (aw_hs && !wfire),
    .drain (wfire),
    .din   (aw_live_idx),
    .held  (aw_held),
    .dout  (aw_hold_idx)
  );

  axil_wr_hold #(.W(STRBW + DW)) u_w_hold (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .load  (w_hs && !wfire),
    .drain (wfire),
    .din   ({s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA}),
    .held  (w_held),
    .dout  (w_hold_pl)
  );

  // Effective write beat: held copy takes precedence over the live bus.
  assign w_idx            = aw_held ? aw_hold_idx : aw_live_idx;
  assign w_pl             = w_held ? w_hold_pl : {s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA};
  assign {wstrb, wdata}   = w_pl;
  assign w_in_range       = 32'(w_idx)  < NUM_REGS;
  assign ar_in_range      = 32'(ar_idx) < NUM_REGS;

  for (genvar k = 0; k < int'(STRBW); k++) begin : g_mask
    assign wmask[k*8 +: 8] = {8{wstrb[k]}};
  end

  // Register storage; the read mux is an OR chain of index-matched words,
  // so an out-of-range index naturally reads as zero.
  assign rd_acc[0] = '0;
  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    logic [DW-1:0] q;

    always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
        q <= '0;
      end else if (wfire && (w_idx == IDXW'(i))) begin
        q <= (q & ~wmask) | (wdata & wmask);
      end
    end

    assign o_regs[i*DW +: DW] = q;
    assign rd_acc[i+1]        = rd_acc[i] | ((ar_idx == IDXW'(i)) ? q : '0);
  end

  // Write response: held until BREADY, reloaded back-to-back on a new fire.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      s_axi.S_AXI_BVALID <= 1'b0;
      s_axi.S_AXI_BRESP  <= RESP_OKAY;
    end else if (wfire) begin
      s_axi.S_AXI_BVALID <= 1'b1;
      s_axi.S_AXI_BRESP  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi.S_AXI_BREADY) begin
      s_axi.S_AXI_BVALID <= 1'b0;
    end
  end

  // Read response: sampled from pre-write register state at the AR edge.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      s_axi.S_AXI_RVALID <= 1'b0;
      s_axi.S_AXI_RDATA  <= '0;
      s_axi.S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi.S_AXI_RVALID <= 1'b1;
      s_axi.S_AXI_RDATA  <= rd_acc[NUM_REGS];
      s_axi.S_AXI_RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi.S_AXI_RREADY) begin
      s_axi.S_AXI_RVALID <= 1'b0;
      if (OPT_LOWPOWER) s_axi.S_AXI_RDATA <= '0;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile (32-bit data, 7-bit address, 20 regs).
// A plain array of register words plus byte-strobe merging serves as the
// reference; stimulus is driven on the falling edge and sampled 1 time unit later.
module tb_axil_regfile;
  import axil_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 7;
  localparam int unsigned NREGS = 20;

  logic                clk;
  logic                rst;
  logic [NREGS*DW-1:0] o_regs;

  axil_regfile_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) axi ();

  axil_regfile #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .NUM_REGS           (NREGS),
    .OPT_LOWPOWER       (1'b0)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (axi),
    .o_regs       (o_regs)
  );

  int          checks;
  int          errors;
  logic [31:0] m_regs [NREGS];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [NREGS*DW-1:0] model_flat();
    logic [NREGS*DW-1:0] r;
    for (int i = 0; i < int'(NREGS); i++) r[i*32 +: 32] = m_regs[i];
    return r;
  endfunction

  task automatic idle_inputs();
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0;
    axi.S_AXI_WVALID  = 1'b0; axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0;
    axi.S_AXI_BREADY  = 1'b1;
    axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0;
    axi.S_AXI_RREADY  = 1'b1;
  endtask

  // Issues one write with independent AW/W start delays; returns B response.
  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input bit rnd_bready,
                          output logic [1:0] resp, output bit timeout);
    bit aw_done, w_done, b_done;
    int c;
    aw_done = 0; w_done = 0; b_done = 0; c = 0; timeout = 0; resp = 2'b11;
    while (!b_done && !timeout) begin
      @(negedge clk);
      if (c > 60) begin
        timeout = 1;
        idle_inputs();
      end else begin
        axi.S_AXI_AWVALID = !aw_done && (c >= aw_dly);
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_WVALID  = !w_done && (c >= w_dly);
        axi.S_AXI_WDATA   = data;
        axi.S_AXI_WSTRB   = strb;
        axi.S_AXI_BREADY  = rnd_bready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) aw_done = 1;
        if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) w_done = 1;
        if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
          b_done = 1;
          resp   = axi.S_AXI_BRESP;
        end
        c++;
      end
    end
  endtask

  // Issues one read after ar_dly cycles with random RREADY stalls.
  task automatic do_read(input logic [6:0] addr, input int ar_dly,
                         output logic [31:0] data, output logic [1:0] resp, output bit timeout);
    bit ar_done, r_done;
    int c;
    ar_done = 0; r_done = 0; c = 0; timeout = 0; data = '0; resp = 2'b11;
    while (!r_done && !timeout) begin
      @(negedge clk);
      if (c > 60) begin
        timeout = 1;
        idle_inputs();
      end else begin
        axi.S_AXI_ARVALID = !ar_done && (c >= ar_dly);
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_RREADY  = 1'($urandom_range(0, 1));
        #1;
        if (axi.S_AXI_ARVALID && axi.S_AXI_ARREADY) ar_done = 1;
        if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
          r_done = 1;
          data   = axi.S_AXI_RDATA;
          resp   = axi.S_AXI_RRESP;
        end
        c++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_WDATA = 32'hDEADBEEF; axi.S_AXI_WSTRB = 4'hF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b000) begin
        errors++;
        $display("FAIL reset_readys: got %b required 000", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
      end
      checks++;
      if ({axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 2'b00) begin
        errors++;
        $display("FAIL reset_valids: got %b required 00", {axi.S_AXI_BVALID, axi.S_AXI_RVALID});
      end
      checks++;
      if (o_regs !== '0) begin
        errors++;
        $display("FAIL reset_regs: got %h required 0", o_regs);
      end
    end
    checks++;
    if ({axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA} !== 36'd0) begin
      errors++;
      $display("FAIL reset_resp_data: got %h required 0", {axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA});
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL post_reset_readys: got %b required 111", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
    end
    for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] old17;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_AWADDR = 7'h40;
    axi.S_AXI_WVALID  = 1'b1; axi.S_AXI_WDATA  = 32'h80000000; axi.S_AXI_WSTRB = 4'b1000;
    axi.S_AXI_BREADY  = 1'b1;
    axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_ARADDR = 7'h44; axi.S_AXI_RREADY = 1'b0;
    #1;
    checks++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL simul_readys: got %b required 111", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
    end
    old17     = m_regs[17];
    m_regs[16] = merge(m_regs[16], 32'h80000000, 4'b1000);
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
    #1;
    checks++;
    if (o_regs[16*32 +: 32] !== 32'h80000000 || o_regs !== model_flat()) begin
      errors++;
      $display("FAIL simul_reg16: got %h required %h", o_regs[16*32 +: 32], 32'h80000000);
    end
    checks++;
    if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP} !== {1'b1, RESP_OKAY}) begin
      errors++;
      $display("FAIL simul_b: got %b required 100", {axi.S_AXI_BVALID, axi.S_AXI_BRESP});
    end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
        checks++;
        if (axi.S_AXI_BVALID !== 1'b0) begin
          errors++;
          $display("FAIL simul_b_pulse: got %b required 0 at cycle %0d", axi.S_AXI_BVALID, c);
        end
      end
      checks++;
      if ({axi.S_AXI_RVALID, axi.S_AXI_RRESP, axi.S_AXI_RDATA} !== {1'b1, RESP_OKAY, old17}) begin
        errors++;
        $display("FAIL simul_r_hold: got %b/%b/%h required 1/00/%h at cycle %0d",
                 axi.S_AXI_RVALID, axi.S_AXI_RRESP, axi.S_AXI_RDATA, old17, c);
      end
      checks++;
      if (axi.S_AXI_ARREADY !== 1'b0) begin
        errors++;
        $display("FAIL simul_arready_stall: got %b required 0 at cycle %0d", axi.S_AXI_ARREADY, c);
      end
    end
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b1;
    #1;
    @(negedge clk); #1;
    checks++;
    if (axi.S_AXI_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL simul_r_release: got %b required 0", axi.S_AXI_RVALID);
    end
  endtask

  task automatic test_w_before_aw();
    int bcount, bcycle;
    bcount = 0; bcycle = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      axi.S_AXI_WVALID  = (c == 2);
      axi.S_AXI_AWVALID = (c == 5);
      axi.S_AXI_AWADDR  = 7'h08;
      axi.S_AXI_WDATA   = 32'hAABBCCDD;
      axi.S_AXI_WSTRB   = 4'b0011;
      axi.S_AXI_BREADY  = 1'b1;
      #1;
      checks++;
      if (axi.S_AXI_WREADY !== !(c >= 3 && c <= 5)) begin
        errors++;
        $display("FAIL wfirst_wready: got %b required %b at cycle %0d", axi.S_AXI_WREADY, !(c >= 3 && c <= 5), c);
      end
      if (axi.S_AXI_BVALID === 1'b1) begin
        bcount++;
        bcycle = c;
        checks++;
        if (axi.S_AXI_BRESP !== RESP_OKAY) begin
          errors++;
          $display("FAIL wfirst_bresp: got %b required 00", axi.S_AXI_BRESP);
        end
      end
    end
    m_regs[2] = merge(m_regs[2], 32'hAABBCCDD, 4'b0011);
    checks++;
    if (bcount != 1 || bcycle != 6) begin
      errors++;
      $display("FAIL wfirst_bcount: got %0d responses at cycle %0d required 1 at cycle 6", bcount, bcycle);
    end
    checks++;
    if (o_regs[2*32 +: 32] !== 32'h0000CCDD || o_regs !== model_flat()) begin
      errors++;
      $display("FAIL wfirst_reg2: got %h required 0000ccdd", o_regs[2*32 +: 32]);
    end
  endtask

  task automatic test_b_backpressure();
    logic [31:0] d1;
    d1 = $urandom;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      axi.S_AXI_AWVALID = (c == 0) || (c == 1);
      axi.S_AXI_WVALID  = (c == 0) || (c == 1);
      axi.S_AXI_AWADDR  = (c == 0) ? 7'h10 : 7'h60;
      axi.S_AXI_WDATA   = (c == 0) ? d1 : 32'h12345678;
      axi.S_AXI_WSTRB   = 4'hF;
      axi.S_AXI_BREADY  = (c >= 5);
      #1;
      if (c == 0) m_regs[4] = d1;
      checks++;
      if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== ((c >= 2 && c <= 5) ? 2'b00 : 2'b11)) begin
        errors++;
        $display("FAIL bp_readys: got %b at cycle %0d", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, c);
      end
      if (c >= 1) begin
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP} !==
            ((c == 7) ? {1'b0, axi.S_AXI_BRESP} : {1'b1, (c == 6) ? RESP_SLVERR : RESP_OKAY})) begin
          errors++;
          $display("FAIL bp_b: got %b/%b at cycle %0d", axi.S_AXI_BVALID, axi.S_AXI_BRESP, c);
        end
        checks++;
        if (o_regs !== model_flat()) begin
          errors++;
          $display("FAIL bp_regs: got %h required %h", o_regs, model_flat());
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      axi.S_AXI_AWVALID = (c == 0); axi.S_AXI_AWADDR = 7'h50;
      axi.S_AXI_WVALID  = (c == 0); axi.S_AXI_WDATA  = 32'hFFFFFFFF; axi.S_AXI_WSTRB = 4'hF;
      axi.S_AXI_BREADY  = 1'b1; axi.S_AXI_RREADY = 1'b1;
      axi.S_AXI_ARVALID = (c == 1) || (c == 2);
      axi.S_AXI_ARADDR  = (c == 1) ? 7'h50 : 7'h4C;
      #1;
      if (c == 1) begin
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP} !== {1'b1, RESP_SLVERR}) begin
          errors++;
          $display("FAIL oor_bresp: got %b/%b required 1/10", axi.S_AXI_BVALID, axi.S_AXI_BRESP);
        end
        checks++;
        if (o_regs !== model_flat()) begin
          errors++;
          $display("FAIL oor_regs: got %h required %h", o_regs, model_flat());
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if ({axi.S_AXI_RVALID, axi.S_AXI_RRESP, axi.S_AXI_RDATA} !==
            ((c == 2) ? {1'b1, RESP_SLVERR, 32'h0} : {1'b1, RESP_OKAY, m_regs[19]})) begin
          errors++;
          $display("FAIL oor_read: got %b/%b/%h at cycle %0d", axi.S_AXI_RVALID, axi.S_AXI_RRESP, axi.S_AXI_RDATA, c);
        end
      end
    end
  endtask

  task automatic test_same_idx();
    logic [31:0] old_v, nd;
    logic [3:0]  st;
    logic [1:0]  resp;
    bit          to;
    do_write(7'h48, $urandom, 4'hF, 0, 0, 1'b0, resp, to);
    checks++;
    if (to || resp !== RESP_OKAY) begin
      errors++;
      $display("FAIL same_pre_write: timeout %0d resp %b required 00", to, resp);
    end
    m_regs[18] = o_regs[18*32 +: 32];
    old_v = m_regs[18];
    nd = $urandom; st = 4'($urandom_range(1, 15));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      axi.S_AXI_AWVALID = (c == 0); axi.S_AXI_WVALID = (c == 0);
      axi.S_AXI_AWADDR = 7'h48; axi.S_AXI_WDATA = nd; axi.S_AXI_WSTRB = st;
      axi.S_AXI_ARVALID = (c <= 1); axi.S_AXI_ARADDR = 7'h48;
      axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
      #1;
      if (c == 0) m_regs[18] = merge(old_v, nd, st);
      if (c >= 1) begin
        checks++;
        if ({axi.S_AXI_RVALID, axi.S_AXI_RDATA} !== {1'b1, (c == 1) ? old_v : m_regs[18]}) begin
          errors++;
          $display("FAIL same_idx_read: got %b/%h required 1/%h at cycle %0d",
                   axi.S_AXI_RVALID, axi.S_AXI_RDATA, (c == 1) ? old_v : m_regs[18], c);
        end
      end
    end
  endtask

  task automatic test_back_to_back_reads();
    logic [1:0] resp;
    bit         to;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = $urandom;
      do_write(7'(i * 4), d, 4'hF, 0, 0, 1'b0, resp, to);
      m_regs[i] = d;
      checks++;
      if (to) begin
        errors++;
        $display("FAIL b2b_preload: write %0d timed out", i);
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle_inputs();
      axi.S_AXI_ARVALID = (c < 4);
      axi.S_AXI_ARADDR  = 7'(c * 4);
      #1;
      checks++;
      if (axi.S_AXI_ARREADY !== 1'b1) begin
        errors++;
        $display("FAIL b2b_arready: got %b required 1 at cycle %0d", axi.S_AXI_ARREADY, c);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if ({axi.S_AXI_RVALID, axi.S_AXI_RRESP, axi.S_AXI_RDATA} !== {1'b1, RESP_OKAY, m_regs[c-1]}) begin
          errors++;
          $display("FAIL b2b_rdata: got %b/%b/%h required 1/00/%h at cycle %0d",
                   axi.S_AXI_RVALID, axi.S_AXI_RRESP, axi.S_AXI_RDATA, m_regs[c-1], c);
        end
      end else if (c == 5) begin
        checks++;
        if (axi.S_AXI_RVALID !== 1'b0) begin
          errors++;
          $display("FAIL b2b_rvalid_end: got %b required 0", axi.S_AXI_RVALID);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          idx, ridx;
      logic [31:0] d, rd;
      logic [3:0]  st;
      logic [1:0]  resp;
      bit          to;
      idx = $urandom_range(0, 23);
      d   = $urandom;
      st  = 4'($urandom_range(0, 15));
      do_write(7'(idx * 4 + $urandom_range(0, 3)), d, st,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, resp, to);
      if (idx < int'(NREGS)) m_regs[idx] = merge(m_regs[idx], d, st);
      checks++;
      if (to || resp !== ((idx < int'(NREGS)) ? RESP_OKAY : RESP_SLVERR)) begin
        errors++;
        $display("FAIL rnd_bresp: idx %0d timeout %0d got %b", idx, to, resp);
      end
      checks++;
      if (o_regs !== model_flat()) begin
        errors++;
        $display("FAIL rnd_regs: idx %0d got %h required %h", idx, o_regs, model_flat());
      end
      ridx = $urandom_range(0, 23);
      do_read(7'(ridx * 4 + $urandom_range(0, 3)), $urandom_range(0, 2), rd, resp, to);
      checks++;
      if (to || {resp, rd} !== ((ridx < int'(NREGS)) ? {RESP_OKAY, m_regs[ridx]} : {RESP_SLVERR, 32'h0})) begin
        errors++;
        $display("FAIL rnd_read: idx %0d timeout %0d got %b/%h", ridx, to, resp, rd);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_simultaneous();
    test_w_before_aw();
    test_b_backpressure();
    test_out_of_range();
    test_same_idx();
    test_back_to_back_reads();
    test_random();
    @(negedge clk);
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed 32x32 demo slave.
- Generalised in data width and register count, with independent AW/W acceptance and back-pressure-correct B/R channels (valid held until ready, no dropped responses), plus an SLVERR response for out-of-range addresses.
- Exports all register contents as a flat bus for downstream control logic.
- Sits between the AXI-Lite interconnect and peripheral control/status fabric.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width; 32 or 64.
- C_S_AXI_ADDR_WIDTH, 7: byte address width.
- NUM_REGS, 32: implemented registers; 1..2**(C_S_AXI_ADDR_WIDTH-ADDRLSB).
- OPT_LOWPOWER, 0: if 1, S_AXI_RDATA is forced to 0 whenever S_AXI_RVALID=0.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  reset: synchronous, active-high.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_BRESP  out  2  write response: OKAY=00, SLVERR=10.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- o_regs  out  NUM_REGS*C_S_AXI_DATA_WIDTH  register contents; reg i occupies bits [i*DW +: DW].

Behaviour:
- Reset, synchronous on S_AXI_ARESET=1 at a clock edge:
  - AWREADY=WREADY=ARREADY=0 during the reset cycle, then 1.
  - BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0.
  - All registers and both hold buffers cleared.
  - Reset mid-transaction abandons it; no response is issued afterwards.
- Address decode:
  - ADDRLSB = log2(DW/8).
  - idx = addr[ADDR_W-1:ADDRLSB]; the low ADDRLSB bits are ignored.
  - idx >= NUM_REGS is out of range.
- Write path:
  - Separate 1-deep AW hold and W hold; AWREADY = !aw_held, WREADY = !w_held.
  - addr_avail = aw_held | AWVALID; data_avail = w_held | WVALID; b_free = !BVALID | BREADY.
  - wfire = addr_avail & data_avail & b_free.
  - On wfire:
    - Registers update at that edge: each byte lane k where WSTRB[k]=1 is written; an out-of-range address writes nothing.
    - BVALID=1 next cycle; BRESP=00 if in range, else 10.
    - Holds used by the fire are cleared.
  - A handshaken AW or W that does not fire is captured in its hold.
  - Either order is accepted; AW may lead W by any number of cycles, and vice versa.
  - BVALID and BRESP stay stable until BREADY. When BREADY=1 and a new wfire occurs in the same cycle, BVALID stays 1 (back-to-back).
  - Throughput is 1 write per cycle when BREADY stays 1.
- Read path:
  - ARREADY = !RVALID | RREADY (combinational from RREADY is permitted).
  - On AR handshake, next cycle: RVALID=1, RDATA = reg[idx] (value before any same-edge write), RRESP=00.
  - Out of range: RDATA=0, RRESP=10.
  - RVALID, RDATA and RRESP stay stable until RREADY.
  - When RVALID=1 and RREADY=0, no new read is accepted.
  - Throughput is 1 read per cycle.
- Read and write paths are fully independent. A simultaneous read and write to the same idx returns the old value; the write is visible to reads issued on later cycles.
- o_regs reflects register state one cycle after wfire.

Decomposition:
- Shared package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - A function clog2 for ADDRLSB.
- One natural sub-module: axil_wr_hold, a 1-deep valid/payload hold register.
  - Instantiated twice: AW with payload addr; W with payload data+strb.

Test Plan:
- Reset:
  - Drive S_AXI_ARESET=1 for 2 cycles with AWVALID=WVALID=ARVALID=1.
  - Required: BVALID=RVALID=0 throughout; all o_regs=0; READYs=0 during reset.
- Simultaneous AW+W:
  - AWADDR=0x40, WDATA=0x80000000, WSTRB=1000, BREADY=1, ARVALID=1 with ARADDR=0x44, RREADY=0.
  - Required: reg16=0x80000000 next cycle; BVALID pulses with BRESP=00.
  - Required: RVALID held high with RDATA=0 until RREADY; ARREADY=0 while RVALID=1 and RREADY=0.
- W before AW:
  - Drive WVALID at cycle 2 and AWVALID at cycle 5, with WSTRB=0011 and WDATA=0xAABBCCDD to addr 0x08.
  - Required: reg2=0x0000CCDD; exactly one BVALID; WREADY=0 during cycles 3-5.
- B back-pressure:
  - BREADY=0 for 4 cycles after a write.
  - Required: BVALID and BRESP stable; a second AW/W pair is held with AWREADY=WREADY=0 after capture.
  - Required: on BREADY=1, the second response follows on the next cycle.
- Out of range (NUM_REGS=20):
  - Write 0xFFFFFFFF to addr 0x50, then read 0x50.
  - Required: BRESP=10; no register changes; RRESP=10, RDATA=0.
- Back-to-back reads:
  - ARVALID=RREADY=1 for 4 cycles over addrs 0x00, 0x04, 0x08, 0x0C.
  - Required: RVALID=1 for 4 consecutive cycles with the matching data, and no gaps.
